rc4_init_ksa: RTL and testbench

- Upstream neighbour of the RC4 decrypt/compute stage on DE1-SoC.
- Owns the 256x8 working-memory port before decryption starts.
- Fills S[i]=i for i=0..255, then runs the RC4 key-scheduling pass with a 24-bit secret key.
- Pulses complete so the compute stage can start on the scrambled S array.

---
 rtl/rc4_pkg.sv | 23 ++
 rtl/rc4_key_byte_sel.sv | 23 ++
 rtl/rc4_init_ksa.sv | 190 +++++++++++++++++++
 tb/tb_rc4_init_ksa.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, memory geometry and byte type.
// Imported by the init/KSA block and the downstream compute stage.
package rc4_pkg;

    localparam int MEM_DEPTH         = 256;
    localparam int KEY_BYTES_DEFAULT = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        INIT_WR     = 4'd1,
        KSA_RD_SI   = 4'd2,
        KSA_WAIT_SI = 4'd3,
        KSA_CALC_J  = 4'd4,
        KSA_RD_SJ   = 4'd5,
        KSA_WAIT_SJ = 4'd6,
        KSA_WR_SI   = 4'd7,
        KSA_WR_SJ   = 4'd8,
        DONE        = 4'd9
    } state_t;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Combinational key byte picker: byte 0 is the most significant byte of the key.
// Shared with the compute stage for key sweeps.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
    localparam int IDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  logic [8*KEY_BYTES-1:0] key_i,
    input  logic [IDX_W-1:0]       key_idx_i,
    output byte_t                  key_byte_o
);

    always_comb begin
        key_byte_o = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (key_idx_i == IDX_W'(k)) begin
                key_byte_o = key_i[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

endmodule

// File: rtl/rc4_init_ksa.sv
// RC4 working-memory initialisation (S[i]=i) followed by the key-scheduling pass.
// Optional cycle counter output enabled by macro RC4_INIT_KSA_CYCLE_CNT_EN.
module rc4_init_ksa
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
    parameter int READ_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic                   busy,
    output logic                   complete
`ifdef RC4_INIT_KSA_CYCLE_CNT_EN
    ,
    output logic [15:0]            cycle_count
`endif
);

    localparam int IDX_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam byte_t             LAST_IDX  = byte_t'(MEM_DEPTH - 1);
    localparam logic [IDX_W-1:0]  KEY_LAST  = IDX_W'(KEY_BYTES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

    state_t                 state_q, state_d;
    byte_t                  i_q, i_d, j_q, j_d;
    logic [IDX_W-1:0]       kidx_q, kidx_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    byte_t                  addr_q, addr_d, data_q, data_d;
    logic                   wren_q, wren_d, busy_q, busy_d, complete_q, complete_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    byte_t                  si_q, si_d;
    byte_t                  key_byte;

    rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
        .key_i      (key_q),
        .key_idx_i  (kidx_q),
        .key_byte_o (key_byte)
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        kidx_d     = kidx_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        busy_d     = busy_q;
        complete_d = 1'b0;
        key_d      = key_q;
        si_d       = si_q;
        // Outputs are registered, so each branch loads the values seen in the next state.
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = secret_key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    addr_d  = '0;
                    data_d  = '0;
                    wren_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = INIT_WR;
                end
            end
            INIT_WR: begin
                if (i_q == LAST_IDX) begin
                    i_d     = '0;
                    addr_d  = '0;
                    state_d = KSA_RD_SI;
                end else begin
                    i_d    = i_q + 8'd1;
                    addr_d = i_q + 8'd1;
                    data_d = i_q + 8'd1;
                    wren_d = 1'b1;
                end
            end
            KSA_RD_SI: begin
                wait_d  = '0;
                state_d = KSA_WAIT_SI;
            end
            KSA_WAIT_SI: begin
                if (wait_q == WAIT_LAST) state_d = KSA_CALC_J;
                else                     wait_d  = wait_q + 1'b1;
            end
            KSA_CALC_J: begin
                si_d    = q;
                j_d     = j_q + q + key_byte;
                addr_d  = j_q + q + key_byte;
                state_d = KSA_RD_SJ;
            end
            KSA_RD_SJ: begin
                wait_d  = '0;
                state_d = KSA_WAIT_SJ;
            end
            KSA_WAIT_SJ: begin
                if (wait_q == WAIT_LAST) begin
                    addr_d  = i_q;
                    data_d  = q;
                    wren_d  = 1'b1;
                    state_d = KSA_WR_SI;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            KSA_WR_SI: begin
                addr_d  = j_q;
                data_d  = si_q;
                wren_d  = 1'b1;
                state_d = KSA_WR_SJ;
            end
            KSA_WR_SJ: begin
                kidx_d = (kidx_q == KEY_LAST) ? '0 : kidx_q + 1'b1;
                if (i_q == LAST_IDX) begin
                    complete_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    addr_d  = i_q + 8'd1;
                    state_d = KSA_RD_SI;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            kidx_q     <= '0;
            wait_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            kidx_q     <= kidx_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
        end
    end

    // Datapath holding registers: always reloaded before use, so no reset.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        si_q  <= si_d;
    end

    assign address  = addr_q;
    assign data     = data_q;
    assign wren     = wren_q;
    assign busy     = busy_q;
    assign complete = complete_q;

`ifdef RC4_INIT_KSA_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          cnt_q <= '0;
        else if (state_q == IDLE && start)  cnt_q <= '0;
        else if (busy_q)                    cnt_q <= cnt_q + 16'd1;
    end

    assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_rc4_init_ksa.sv
// Directed bench for rc4_init_ksa with a registered-address RAM model and a software KSA reference.
module tb_rc4_init_ksa;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        busy;
    logic        complete;
`ifdef RC4_INIT_KSA_CYCLE_CNT_EN
    logic [15:0] cycle_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rc4_init_ksa dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .complete   (complete)
`ifdef RC4_INIT_KSA_CYCLE_CNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    // On-chip RAM model: address registered on the clock edge, read data follows it.
    logic [7:0] mem [256];
    logic [7:0] addr_r;
    always @(posedge clk) begin
        if (wren) mem[address] <= data;
        addr_r <= address;
    end
    assign q = mem[addr_r];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] gs [256];
    logic [7:0] kb [3];
    logic [7:0] gj, gt;
    int         cpl_cnt, cpl_cyc;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        secret_key = 24'h000249;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);

        // Abort partway through the fill with an asynchronous reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_first_wren", 32'(wren), 32'd1);
        chk("init_first_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 100; k++) tick();
        chk("mid_init_addr", 32'(address), 32'd100);
        reset = 1'b1;
        #1;
        chk("async_rst_wren", 32'(wren), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_addr", 32'(address), 32'd0);
        tick();
        chk("rst_next_wren", 32'(wren), 32'd0);
        chk("rst_next_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Full run; a stray start at KSA i=50 must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        cpl_cnt = 0;
        cpl_cyc = 0;
        for (int cyc = 1; cyc <= 2055; cyc++) begin
            if (wren) begin
                wa.push_back(address);
                wd.push_back(data);
            end
            if (complete) begin
                cpl_cnt++;
                if (cpl_cyc == 0) cpl_cyc = cyc;
            end
            if (cyc == 256) chk("init_last_wren", 32'(wren), 32'd1);
            if (cyc == 257) chk("init_end_wren", 32'(wren), 32'd0);
            if (cyc == 607) chk("busy_at_restart_try", 32'(busy), 32'd1);
            if (cyc == 2049) chk("busy_in_done", 32'(busy), 32'd1);
            if (cyc == 2050) chk("busy_after_done", 32'(busy), 32'd0);
            start = (cyc == 607);
            tick();
        end
        start = 1'b0;

        chk("complete_pulses", 32'(cpl_cnt), 32'd1);
        chk("complete_cycle", 32'(cpl_cyc), 32'd2049);
        chk("wren_cycles", 32'(wa.size()), 32'd768);
        while (wa.size() < 768) begin
            wa.push_back(8'hxx);
            wd.push_back(8'hxx);
        end
        chk("init_w0", {16'd0, wa[0], wd[0]}, 32'h0000);
        chk("init_w255", {16'd0, wa[255], wd[255]}, 32'hFFFF);
        chk("ksa_i0_wsi", {16'd0, wa[256], wd[256]}, 32'h0000);
        chk("ksa_i0_wsj", {16'd0, wa[257], wd[257]}, 32'h0000);
        chk("ksa_i1_wsi", {16'd0, wa[258], wd[258]}, 32'h0103);
        chk("ksa_i1_wsj", {16'd0, wa[259], wd[259]}, 32'h0301);
        chk("ksa_i2_wsi", {16'd0, wa[260], wd[260]}, 32'h024E);
        chk("ksa_i2_wsj", {16'd0, wa[261], wd[261]}, 32'h4E02);

        // Software RC4 key schedule for key 00 02 49.
        kb[0] = 8'h00;
        kb[1] = 8'h02;
        kb[2] = 8'h49;
        for (int k = 0; k < 256; k++) gs[k] = k[7:0];
        gj = 8'h00;
        for (int k = 0; k < 256; k++) begin
            gj     = gj + gs[k] + kb[k % 3];
            gt     = gs[k];
            gs[k]  = gs[gj];
            gs[gj] = gt;
        end
        for (int k = 0; k < 256; k++) chk($sformatf("S[%0d]", k), 32'(mem[k]), 32'(gs[k]));

`ifdef RC4_INIT_KSA_CYCLE_CNT_EN
        chk("cycle_count_done", 32'(cycle_count), 32'd2049);
        tick();
        tick();
        chk("cycle_count_hold", 32'(cycle_count), 32'd2049);
`endif

        // A fresh start begins the fill again at address 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_addr", 32'(address), 32'd0);
        chk("restart_data", 32'(data), 32'd0);
        chk("restart_wren", 32'(wren), 32'd1);
`ifdef RC4_INIT_KSA_CYCLE_CNT_EN
        chk("cycle_count_clear", 32'(cycle_count), 32'd0);
`endif
        tick();
        chk("restart_addr1", 32'(address), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
